// File: rtl/uart_seg_display.sv
// UART byte capture into a 16-bit nibble buffer, driving a 4-digit multiplexed
// common-anode hex display. Optional ASCII hex entry when UART_SEG_ASCII_HEX_EN is defined.
module uart_seg_display #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic       clkin,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_byte,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic [7:0] rx_count
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    logic [15:0]   data_buf_reg, data_buf_next;
    logic [3:0]    vmask_reg, vmask_next;
    logic [1:0]    sel_reg;
    logic [CW-1:0] cnt_reg;
    logic [7:0]    rx_count_reg;
    logic [3:0]    an_reg, an_next;
    logic [6:0]    seg_reg, seg_next;
    logic          dp_reg, dp_next;
    logic          digit_on;
    logic [3:0]    nib;
    logic          wrap;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'b1000000;
            4'h1: r = 7'b1111001;
            4'h2: r = 7'b0100100;
            4'h3: r = 7'b0110000;
            4'h4: r = 7'b0011001;
            4'h5: r = 7'b0010010;
            4'h6: r = 7'b0000010;
            4'h7: r = 7'b1111000;
            4'h8: r = 7'b0000000;
            4'h9: r = 7'b0010000;
            4'hA: r = 7'b0001000;
            4'hB: r = 7'b0000011;
            4'hC: r = 7'b1000110;
            4'hD: r = 7'b0100001;
            4'hE: r = 7'b0000110;
            default: r = 7'b0001110;
        endcase
        return r;
    endfunction

`ifdef UART_SEG_ASCII_HEX_EN
    logic err_reg, err_next;

    // Returns {is_hex, nibble} for an ASCII character.
    function automatic logic [4:0] ascii_nib(input logic [7:0] c);
        logic [4:0] r;
        r = 5'b0_0000;
        if (c >= 8'h30 && c <= 8'h39)      r = {1'b1, c[3:0]};
        else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
            r = {1'b1, c[3:0] + 4'd9};
        return r;
    endfunction

    logic [4:0] conv;

    always_comb begin
        data_buf_next = data_buf_reg;
        vmask_next    = vmask_reg;
        err_next      = err_reg;
        conv          = ascii_nib(rx_byte);
        if (rx_valid) begin
            if (conv[4]) begin
                data_buf_next = {data_buf_reg[11:0], conv[3:0]};
                vmask_next    = {vmask_reg[2:0], 1'b1};
                err_next      = 1'b0;
            end else if (rx_byte == 8'h0D) begin
                data_buf_next = 16'h0000;
                vmask_next    = 4'b0000;
                err_next      = 1'b0;
            end else begin
                err_next      = 1'b1;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) err_reg <= 1'b0;
        else        err_reg <= err_next;
    end
`else
    always_comb begin
        data_buf_next = data_buf_reg;
        vmask_next    = vmask_reg;
        if (rx_valid) begin
            data_buf_next = {data_buf_reg[7:0], rx_byte};
            vmask_next    = {vmask_reg[1:0], 2'b11};
        end
    end
`endif

    assign wrap = (cnt_reg == CW'(REFRESH_DIV - 1));

    always_comb begin
        case (sel_reg)
            2'd0:    nib = data_buf_reg[3:0];
            2'd1:    nib = data_buf_reg[7:4];
            2'd2:    nib = data_buf_reg[11:8];
            default: nib = data_buf_reg[15:12];
        endcase
        // A digit lights only outside the blanking window and once it holds data.
        digit_on = (cnt_reg >= CW'(BLANK_CYCLES)) && vmask_reg[sel_reg];
        an_next  = digit_on ? ~(4'b0001 << sel_reg) : 4'b1111;
        seg_next = digit_on ? hex7(nib) : 7'h7F;
`ifdef UART_SEG_ASCII_HEX_EN
        dp_next  = an_next[0] | ~err_reg;
`else
        dp_next  = an_next[2];
`endif
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            data_buf_reg <= 16'h0000;
            vmask_reg    <= 4'b0000;
            sel_reg      <= 2'd0;
            cnt_reg      <= '0;
            rx_count_reg <= 8'd0;
            an_reg       <= 4'b1111;
            seg_reg      <= 7'h7F;
            dp_reg       <= 1'b1;
        end else begin
            data_buf_reg <= data_buf_next;
            vmask_reg    <= vmask_next;
            if (rx_valid) rx_count_reg <= rx_count_reg + 8'd1;
            if (wrap) begin
                cnt_reg <= '0;
                sel_reg <= sel_reg + 2'd1;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            an_reg  <= an_next;
            seg_reg <= seg_next;
            dp_reg  <= dp_next;
        end
    end

    assign an       = an_reg;
    assign seg      = seg_reg;
    assign dp       = dp_reg;
    assign rx_count = rx_count_reg;

endmodule

// File: doc/uart_seg_display.md
Name: uart_seg_display

Overview:
- Sits directly downstream of the UART receiver.
- Consumes the receiver's one-cycle valid pulse and 8-bit parallel byte, then keeps the most recent received data in a 16-bit nibble buffer.
- Drives a 4-digit, time-multiplexed, common-anode seven-segment display with hex decode, anti-ghosting blanking and leading-digit blanking.
- Target: 100 MHz board clock; all display outputs are active-low.

Parameters:
- REFRESH_DIV, 100000, clock cycles each digit is selected (1 kHz per digit at 100 MHz); legal range 4..2^20-1.
- BLANK_CYCLES, 16, cycles all anodes are held off at the start of each digit slot; must be < REFRESH_DIV.

Ports:
- clkin  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx_valid  input  1  one-cycle pulse from the receiver; the byte is valid in the same cycle.
- rx_byte  input  8  received byte, sampled only when rx_valid=1.
- an  output  4  digit anodes, active-low, at most one low at a time; an[0] is the rightmost digit.
- seg  output  7  segments, active-low; seg[0]=a … seg[6]=g.
- dp  output  1  decimal point, active-low.
- rx_count  output  8  number of accepted bytes; wraps 255->0.

Behaviour:
- Clock/reset (fixed): one clock, clkin; reset is asynchronous, active-low (rst_n).
- Reset values:
  - Outputs: an=4'b1111, seg=7'h7F, dp=1, rx_count=0.
  - Internal: buffer=16'h0000, valid mask=4'b0000, digit select=0, refresh counter=0, err=0.
- Capture (raw mode, macro undefined):
  - On rx_valid=1: buf <= {buf[7:0], rx_byte}; vmask <= {vmask[1:0], 2'b11}; rx_count <= rx_count+1.
  - Buffer and count update 1 cycle after the pulse.
- Refresh counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit select advances 0->1->2->3->0.
- Anode drive (registered, 1-cycle latency from counter/select):
  - While counter < BLANK_CYCLES: an=4'b1111.
  - Otherwise: an = ~(4'b0001 << sel), but only if vmask[sel]=1; if vmask[sel]=0 the digit stays blank (an=4'b1111).
- Digit source: sel=0 -> buf[3:0], sel=1 -> buf[7:4], sel=2 -> buf[11:8], sel=3 -> buf[15:12].
- Hex decode (registered, aligned with an), active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000,
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000,
  - 8=0000000, 9=0010000, A=0001000, b=0000011,
  - C=1000110, d=0100001, E=0000110, F=0001110.
  - During blanking, seg=7'h7F.
- dp (raw mode): low only when an[2] is low, separating the two displayed bytes; otherwise 1.
- Simultaneous rx_valid and digit advance: both take effect in the same cycle; the displayed value reflects the new buffer one cycle later. No byte is dropped.
- Back-to-back rx_valid on consecutive cycles: each pulse is accepted.
- Reset asserted mid-slot: outputs return to reset values immediately (asynchronously). Display restarts at sel=0 with all digits blank.

Optional Feature:
- Macro: UART_SEG_ASCII_HEX_EN.
- Defined (ASCII hex entry):
  - Bytes '0'-'9' (0x30-0x39), 'A'-'F' (0x41-0x46), 'a'-'f' (0x61-0x66) are converted to one nibble.
  - Accepted nibble: buf <= {buf[11:0], nib}; vmask <= {vmask[2:0], 1'b1}; err <= 0.
  - CR (0x0D): buf <= 0, vmask <= 0, err <= 0.
  - Any other byte: buffer unchanged; err <= 1 (sticky until the next accepted hex char or CR).
  - rx_count increments on every rx_valid regardless of byte value.
  - dp: low when an[0] is low and err=1; otherwise 1.
- Undefined: raw-mode behaviour above; no err register.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2):
- Reset release, no input -> an stays 4'b1111, seg=7'h7F, rx_count=0 for ≥64 cycles.
- Raw mode: rx_byte=8'h3A pulse ->
  - rx_count=1.
  - sel=0 slot: an=1110, seg=0001000 (A).
  - sel=1 slot: an=1101, seg=0110000 (3).
  - sel=2/3 slots: an=1111.
- Raw mode: send 8'h12 then 8'hEF ->
  - Digits 3..0 show 1,2,E,F.
  - dp=0 only while an=1011.
  - Per 8-cycle slot: cycles 0-1 an=1111, cycles 2-7 one anode low.
- rx_valid coincident with counter wrap, plus back-to-back pulses 8'h01, 8'h02 -> buf=16'h0102, rx_count=2, no byte lost.
- 256 pulses -> rx_count wraps to 0; rst_n pulsed low mid-slot -> an=1111 and seg=7'h7F asynchronously, before the next clock edge.
- ASCII_HEX_EN: send "7","c","Z",0x0D ->
  - After "c": digits 1..0 = 7,c (7 and C patterns).
  - After "Z": buffer unchanged, dp=0 during the an[0] slot.
  - After CR: all digits blank, err=0, rx_count=4.
